systolic_tile_ctrl: RTL and testbench

- Next-generation sequencer for the N×N systolic array. It drives the SRAM address serial number, ALU enable, cycle count, output diagonal index and write-enable.
- Extends the fixed two-data-set controller with:
  - runtime-configurable tile count (number of data sets);
  - a stall input that freezes the datapath;
  - synchronous abort;
  - an explicit, parameterised pipeline drain phase;
  - busy/done/err handshake.
- Sits between the top-level TPU sequencer and the systolic array / address-select / write-out logic.

---
 rtl/systolic_tile_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_systolic_tile_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_tile_ctrl
//
// Sequencer for an N x N systolic array. After an accepted start it walks
// LOAD -> WAIT -> ROLL -> DRAIN -> IDLE. It produces:
//   - the SRAM input address index,
//   - the array shift/multiply enable,
//   - the ROLL/DRAIN cycle counter,
//   - the output diagonal index and the tile (data set) index,
//   - the write-out strobe.
// The number of tiles is configured at run time.
//
// Ports:
//   clk                clock, rising edge
//   srstn              synchronous reset, active-low
//   tpu_start          start request, sampled only in IDLE
//   cfg_tiles          tile count (1..2^TILE_W), latched on accepted start
//   stall              freezes all progress in ROLL/DRAIN
//   abort              synchronous abort back to IDLE (non-IDLE states only)
//   busy               registered, high in every state except IDLE
//   sram_write_enable  write-out strobe (combinational)
//   addr_serial_num    SRAM input address index (saturating)
//   alu_start          array shift/multiply enable (combinational)
//   cycle_num          ROLL/DRAIN cycle counter (saturating)
//   matrix_index       output diagonal index
//   data_set           current tile index
//   tpu_done           one-cycle completion pulse on the first IDLE cycle
//   cfg_err            one-cycle pulse after a start with an illegal cfg_tiles
// ---------------------------------------------------------------------------
module systolic_tile_ctrl #(
  parameter int ARRAY_SIZE      = 8,
  parameter int PIPELINE_MARGIN = 8,
  parameter int TILE_W          = 2,
  parameter int ADDR_W          = 7,
  parameter int CYC_W           = 9,
  parameter int MIDX_W          = 6
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              tpu_start,
  input  logic [TILE_W:0]   cfg_tiles,
  input  logic              stall,
  input  logic              abort,
  output logic              busy,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] addr_serial_num,
  output logic              alu_start,
  output logic [CYC_W-1:0]  cycle_num,
  output logic [MIDX_W-1:0] matrix_index,
  output logic [TILE_W-1:0] data_set,
  output logic              tpu_done,
  output logic              cfg_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ROLL  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [CYC_W-1:0]  FIRST_OUT = CYC_W'(ARRAY_SIZE + 1);
  localparam logic [MIDX_W-1:0] LAST_MIDX = MIDX_W'(2 * ARRAY_SIZE - 1);

  // Drain counter is sized for the margin; with a zero margin DRAIN is never
  // entered and the counter is a single idle bit.
  localparam int DRN_W = (PIPELINE_MARGIN > 1) ? $clog2(PIPELINE_MARGIN) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST =
    DRN_W'((PIPELINE_MARGIN > 0) ? PIPELINE_MARGIN - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [MIDX_W-1:0] midx_q, midx_d;
  logic [TILE_W-1:0] ds_q, ds_d;
  logic [TILE_W:0]   tiles_q, tiles_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              alu_c, we_c;

  logic              tiles_legal;
  logic              last_tile;
  logic [ADDR_W-1:0] addr_inc;
  logic [CYC_W-1:0]  cyc_inc;

  // Legal range is 1..2^TILE_W: non-zero, and if the top bit is set the
  // lower bits must all be zero (exactly 2^TILE_W).
  assign tiles_legal = (cfg_tiles != '0) &&
                       (!cfg_tiles[TILE_W] || (cfg_tiles[TILE_W-1:0] == '0));
  assign last_tile   = ({1'b0, ds_q} == (tiles_q - 1'b1));
  assign addr_inc    = (addr_q == '1) ? addr_q : addr_q + 1'b1;
  assign cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cyc_d   = cyc_q;
    midx_d  = midx_q;
    ds_d    = ds_q;
    tiles_d = tiles_q;
    drn_d   = drn_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    alu_c   = 1'b0;
    we_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tpu_start) begin
          if (tiles_legal) begin
            // Counters are cleared here so a job after a normal completion
            // starts from the same point as one after reset.
            state_d = S_LOAD;
            tiles_d = cfg_tiles;
            addr_d  = '0;
            cyc_d   = '0;
            midx_d  = '0;
            ds_d    = '0;
            drn_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        state_d = S_WAIT;
        addr_d  = ADDR_W'(1);
      end

      S_WAIT: begin
        state_d = S_ROLL;
        addr_d  = ADDR_W'(2);
      end

      S_ROLL: begin
        if (!stall) begin
          alu_c  = 1'b1;
          cyc_d  = cyc_inc;
          addr_d = addr_inc;
          if (cyc_q >= FIRST_OUT) begin
            we_c = 1'b1;
            if (midx_q == LAST_MIDX) begin
              midx_d = '0;
              ds_d   = ds_q + 1'b1;
              if (last_tile) begin
                ds_d = '0;
                if (PIPELINE_MARGIN == 0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end else begin
                  state_d = S_DRAIN;
                end
              end
            end else begin
              midx_d = midx_q + 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (!stall) begin
          alu_c  = 1'b1;
          cyc_d  = cyc_inc;
          addr_d = addr_inc;
          if (drn_q == DRN_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            drn_d   = '0;
          end else begin
            drn_d = drn_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides stall and completion; the address is left where it was.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      cyc_d   = '0;
      midx_d  = '0;
      ds_d    = '0;
      drn_d   = '0;
      done_d  = 1'b0;
      alu_c   = 1'b0;
      we_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      cyc_q   <= '0;
      midx_q  <= '0;
      ds_q    <= '0;
      tiles_q <= '0;
      drn_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      addr_q  <= addr_d;
      cyc_q   <= cyc_d;
      midx_q  <= midx_d;
      ds_q    <= ds_d;
      tiles_q <= tiles_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy              = busy_q;
  assign sram_write_enable = we_c;
  assign alu_start         = alu_c;
  assign addr_serial_num   = addr_q;
  assign cycle_num         = cyc_q;
  assign matrix_index      = midx_q;
  assign data_set          = ds_q;
  assign tpu_done          = done_q;
  assign cfg_err           = err_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for systolic_tile_ctrl.
// Main DUT: N=8, margin 8. Second DUT: N=8, margin 0.
// Expected writes (diagonal index, tile) are queued when a job is started and
// popped whenever the DUT raises sram_write_enable.
// ---------------------------------------------------------------------------
module tb_systolic_tile_ctrl;

  localparam int N         = 8;
  localparam int FIRST_OUT = N + 1;
  localparam int SPAN      = 2 * N;
  localparam int MARGIN    = 8;

  logic       clk = 1'b0;
  logic       srstn, tpu_start, tpu_start1, stall, abort;
  logic [2:0] cfg_tiles;

  logic       busy, we, alu, done, err;
  logic [6:0] addr;
  logic [8:0] cyc;
  logic [5:0] midx;
  logic [1:0] dset;

  logic       busy1, we1, alu1, done1, err1;
  logic [6:0] addr1;
  logic [8:0] cyc1;
  logic [5:0] midx1;
  logic [1:0] dset1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  systolic_tile_ctrl #(.ARRAY_SIZE(N), .PIPELINE_MARGIN(MARGIN)) dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .cfg_tiles(cfg_tiles),
    .stall(stall), .abort(abort), .busy(busy), .sram_write_enable(we),
    .addr_serial_num(addr), .alu_start(alu), .cycle_num(cyc),
    .matrix_index(midx), .data_set(dset), .tpu_done(done), .cfg_err(err)
  );

  systolic_tile_ctrl #(.ARRAY_SIZE(N), .PIPELINE_MARGIN(0)) dut_m0 (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start1), .cfg_tiles(cfg_tiles),
    .stall(stall), .abort(abort), .busy(busy1), .sram_write_enable(we1),
    .addr_serial_num(addr1), .alu_start(alu1), .cycle_num(cyc1),
    .matrix_index(midx1), .data_set(dset1), .tpu_done(done1), .cfg_err(err1)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tpu_start = 1'b0; tpu_start1 = 1'b0; stall = 1'b0; abort = 1'b0;
    end
  endtask

  // One job on the main DUT. Relative cycle 0 is the cycle in which the start
  // is presented. A negative stall_at/abort_at/busy_start_at disables that event.
  task automatic run_job(input string name, input int tiles, input int stall_at,
                         input int stall_len, input int abort_at,
                         input int busy_start_at);
    int  w, l, ecyc, n_stall, n_wr, done_at, addr_hold, e;
    bit  model_done, aborted, seen_done, in_run, exp_alu, exp_we;
    w = tiles * SPAN;
    l = FIRST_OUT + w;
    ecyc = 0; n_stall = 0; n_wr = 0; done_at = -1; addr_hold = 0;
    model_done = 0; aborted = 0; seen_done = 0;
    exp_q.delete();
    for (int i = 0; i < w; i++) exp_q.push_back((i / SPAN) * 256 + (i % SPAN));

    for (int r = 0; r < 300 && !seen_done && !(aborted && r > abort_at + 2); r++) begin
      @(negedge clk);
      tpu_start = (r == 0) || (r == busy_start_at);
      cfg_tiles = (r == 0) ? 3'(tiles) : 3'd1;
      stall     = (stall_at >= 0) && (r >= stall_at) && (r < stall_at + stall_len);
      abort     = (r == abort_at);
      #1;
      in_run = (r >= 3) && !model_done && !aborted;
      chk_eq({name, ":busy"}, int'(busy), int'((r >= 1) && !model_done && !aborted));
      if (in_run) begin
        exp_alu = !stall && !abort;
        exp_we  = exp_alu && (ecyc >= FIRST_OUT) && (ecyc < l);
        chk_eq({name, ":alu_start"}, int'(alu), int'(exp_alu));
        chk_eq({name, ":wr_en"}, int'(we), int'(exp_we));
        chk_eq({name, ":cycle_num"}, int'(cyc), ecyc);
        chk_eq({name, ":addr"}, int'(addr), 2 + ecyc);
        if (exp_we) n_wr++;
      end else if (r == 1 || r == 2) begin
        chk_eq({name, ":addr_pre"}, int'(addr), r - 1);
        chk_eq({name, ":wr_en_pre"}, int'(we), 0);
      end
      if (aborted) begin
        chk_eq({name, ":abort_cyc"}, int'(cyc), 0);
        chk_eq({name, ":abort_midx"}, int'(midx), 0);
        chk_eq({name, ":abort_set"}, int'(dset), 0);
        chk_eq({name, ":abort_addr"}, int'(addr), addr_hold);
      end
      if (we) begin
        if (exp_q.size() == 0) chk_eq({name, ":extra_write"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          chk_eq({name, ":wr_midx"}, int'(midx), e % 256);
          chk_eq({name, ":wr_set"}, int'(dset), e / 256);
        end
      end
      if (done) begin
        seen_done = 1;
        done_at   = r;
        chk_eq({name, ":exit_midx"}, int'(midx), 0);
        chk_eq({name, ":exit_set"}, int'(dset), 0);
      end
      if (in_run) begin
        if (abort) begin
          aborted   = 1;
          addr_hold = 2 + ecyc;
        end else if (stall) begin
          n_stall++;
        end else begin
          ecyc++;
          if (ecyc == l + MARGIN) model_done = 1;
        end
      end
    end
    tpu_start = 1'b0; stall = 1'b0; abort = 1'b0;

    if (abort_at < 0) begin
      chk_eq({name, ":done_cycle"}, done_at, 3 + FIRST_OUT + w + MARGIN + n_stall);
      chk_eq({name, ":writes_left"}, exp_q.size(), 0);
      @(negedge clk); #1;
      chk_eq({name, ":done_single"}, int'(done), 0);
      chk_eq({name, ":busy_after"}, int'(busy), 0);
    end else begin
      chk_eq({name, ":no_done"}, int'(seen_done), 0);
      chk_eq({name, ":writes_left"}, exp_q.size(), w - n_wr);
    end
    $display("job %s: tiles=%0d done_at=%0d stalls=%0d", name, tiles, done_at, n_stall);
  endtask

  task automatic bad_start(input int tiles);
    @(negedge clk);
    tpu_start = 1'b1; cfg_tiles = 3'(tiles);
    #1;
    chk_eq("cfg_err_early", int'(err), 0);
    @(negedge clk);
    tpu_start = 1'b0;
    #1;
    chk_eq("cfg_err_pulse", int'(err), 1);
    chk_eq("cfg_err_busy", int'(busy), 0);
    @(negedge clk); #1;
    chk_eq("cfg_err_clear", int'(err), 0);
    chk_eq("cfg_err_busy2", int'(busy), 0);
    $display("bad start: cfg_tiles=%0d", tiles);
  endtask

  initial begin
    int done_at, n_done, n_writes;
    srstn = 1'b0; tpu_start = 1'b0; tpu_start1 = 1'b0;
    stall = 1'b0; abort = 1'b0; cfg_tiles = 3'd0;
    repeat (3) @(negedge clk);
    srstn = 1'b1;
    #1;
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_addr", int'(addr), 0);
    chk_eq("rst_cyc", int'(cyc), 0);
    chk_eq("rst_midx", int'(midx), 0);
    chk_eq("rst_set", int'(dset), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_err", int'(err), 0);
    chk_eq("rst_wr_en", int'(we), 0);
    idle_cycles(2);

    run_job("t1", 1, -1, 0, -1, -1);
    idle_cycles(2);
    run_job("t4_busystart", 4, -1, 0, -1, 30);
    idle_cycles(2);
    run_job("t1_stall", 1, 15, 5, -1, -1);
    idle_cycles(2);
    run_job("abort", 1, -1, 0, 20, -1);
    idle_cycles(2);
    run_job("restart", 1, -1, 0, -1, -1);
    idle_cycles(2);
    run_job("t2_stall_drain", 2, 45, 3, -1, -1);
    idle_cycles(2);

    bad_start(0);
    bad_start(5);
    idle_cycles(2);

    // Zero drain margin, two tiles on the second instance.
    done_at = -1; n_done = 0; n_writes = 0;
    for (int r = 0; r < 60; r++) begin
      @(negedge clk);
      tpu_start1 = (r == 0);
      cfg_tiles  = 3'd2;
      #1;
      if (we1) n_writes++;
      if (done1) begin
        n_done++;
        if (done_at < 0) done_at = r;
      end
    end
    tpu_start1 = 1'b0;
    chk_eq("m0_done_cycle", done_at, 3 + FIRST_OUT + 2 * SPAN);
    chk_eq("m0_done_count", n_done, 1);
    chk_eq("m0_writes", n_writes, 2 * SPAN);
    chk_eq("m0_busy", int'(busy1), 0);
    $display("job m0: tiles=2 done_at=%0d writes=%0d", done_at, n_writes);
    idle_cycles(2);

    // Reset in the middle of ROLL.
    for (int r = 0; r <= 10; r++) begin
      @(negedge clk);
      tpu_start = (r == 0);
      cfg_tiles = 3'd1;
      srstn     = (r != 10);
    end
    @(negedge clk);
    tpu_start = 1'b0;
    srstn = 1'b1;
    #1;
    chk_eq("mid_rst_busy", int'(busy), 0);
    chk_eq("mid_rst_addr", int'(addr), 0);
    chk_eq("mid_rst_cyc", int'(cyc), 0);
    chk_eq("mid_rst_midx", int'(midx), 0);
    chk_eq("mid_rst_set", int'(dset), 0);
    chk_eq("mid_rst_alu", int'(alu), 0);
    chk_eq("mid_rst_wr_en", int'(we), 0);
    n_done = 0;
    for (int r = 0; r < 40; r++) begin
      @(negedge clk); #1;
      if (done) n_done++;
    end
    chk_eq("mid_rst_no_done", n_done, 0);
    $display("mid-run reset checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
